// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register unit.
// Used by hilo_unit and lat_counter.
package hilo_pkg;

    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF = 32;
    localparam int unsigned CNT_W       = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hilo_state_t;

endpackage

// File: rtl/hilo_unit_lat_counter.sv
// Loadable down-counter with a zero flag that times an in-flight HI/LO operation.
// Present only when HILO_LATENCY_EN is defined.
`ifdef HILO_LATENCY_EN
module lat_counter
    import hilo_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule
`endif

// File: rtl/hilo_unit.sv
// HI/LO register unit: captures ALU multiply/divide results and serves mthi/mtlo/mfhi/mflo.
// Macro HILO_LATENCY_EN: when defined, results commit after MUL_LAT/DIV_LAT busy cycles.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_mul,
    input  logic        start_div,
    input  logic [31:0] alu_r1,
    input  logic [31:0] alu_r2,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        rd_hi,
    input  logic        rd_lo,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall
);

    if (MUL_LAT < 1 || MUL_LAT > 63 || DIV_LAT < 1 || DIV_LAT > 63) begin : g_bad_lat
        $error("hilo_unit: MUL_LAT and DIV_LAT must lie in 1..63");
    end

    logic [31:0] hi;
    logic [31:0] lo;
    logic        start_any;

    assign start_any = start_mul | start_div;

`ifdef HILO_LATENCY_EN
    hilo_state_t      state;
    logic [31:0]      pending_hi;
    logic [31:0]      pending_lo;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;

    assign busy  = (state == BUSY);
    assign stall = busy & (rd_hi | rd_lo | mthi | mtlo | start_mul | start_div);

    // Counter is loaded with LAT-1 so busy spans exactly LAT cycles.
    assign cnt_load     = (state == IDLE) & start_any;
    assign cnt_load_val = start_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);
    assign cnt_dec      = busy & ~cnt_zero;

    lat_counter #(
        .W (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start_any) begin
                        pending_hi <= alu_r2;
                        pending_lo <= alu_r1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        hi    <= pending_hi;
                        lo    <= pending_lo;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign busy  = 1'b0;
    assign stall = 1'b0;

    // Without latency the start result lands on the same edge, so it overrides mthi/mtlo.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (start_any) begin
            hi <= alu_r2;
            lo <= alu_r1;
        end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (rd_hi) begin
            rdata = hi;
        end else if (rd_lo) begin
            rdata = lo;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: stimulus queues expected read responses,
// a negedge monitor pops and compares them whenever a read request is presented.
module tb_hilo_unit;

`ifdef HILO_LATENCY_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif
    localparam int MUL_N = LAT_EN ? 4 : 0;
    localparam int DIV_N = LAT_EN ? 32 : 0;

    logic        clk;
    logic        rst;
    logic        start_mul;
    logic        start_div;
    logic [31:0] alu_r1;
    logic [31:0] alu_r2;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_hi;
    logic        rd_lo;
    logic [31:0] rdata;
    logic        busy;
    logic        stall;

    typedef struct {
        string       name;
        bit          busy;
        bit          stall;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    hilo_unit #(
        .MUL_LAT (4),
        .DIV_LAT (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_mul (start_mul),
        .start_div (start_div),
        .alu_r1    (alu_r1),
        .alu_r2    (alu_r2),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .rd_hi     (rd_hi),
        .rd_lo     (rd_lo),
        .rdata     (rdata),
        .busy      (busy),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string name, input bit b, input bit s, input logic [31:0] d);
        exp_t e;
        e.name  = name;
        e.busy  = b;
        e.stall = s;
        e.rdata = d;
        sb.push_back(e);
    endtask

    // Read request held while the unit is busy: expect busy=1, stall=1 for n cycles.
    task automatic hold_busy(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            expect_rd($sformatf("%s_busy%0d", name, i), 1'b1, 1'b1, 32'h0);
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (rd_hi || rd_lo) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: nothing queued, got busy=%b stall=%b rdata=%h",
                         busy, stall, rdata);
            end else begin
                mon_e = sb.pop_front();
                if (busy !== mon_e.busy || stall !== mon_e.stall ||
                    (!mon_e.stall && rdata !== mon_e.rdata)) begin
                    errors++;
                    $display("FAIL %s: got busy=%b stall=%b rdata=%h, need busy=%b stall=%b rdata=%h",
                             mon_e.name, busy, stall, rdata, mon_e.busy, mon_e.stall, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got %0d queued, need 0", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start_mul = 1'b0; start_div = 1'b0;
        alu_r1 = '0; alu_r2 = '0; mthi = 1'b0; mtlo = 1'b0;
        wdata = '0; rd_hi = 1'b0; rd_lo = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        rd_hi = 1'b1; expect_rd("rst_hi", 0, 0, 32'h0); tick();
        rd_hi = 1'b0; rd_lo = 1'b1; expect_rd("rst_lo", 0, 0, 32'h0); tick();
        rd_lo = 1'b0;

        // mthi then mfhi
        mthi = 1'b1; wdata = 32'h1234_5678; tick();
        mthi = 1'b0;
        rd_hi = 1'b1; expect_rd("mthi_rd", 0, 0, 32'h1234_5678); tick();
        rd_hi = 1'b0;

        // Simultaneous mthi/mtlo
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_BABE; tick();
        mthi = 1'b0; mtlo = 1'b0;
        rd_lo = 1'b1; expect_rd("mtlo_rd", 0, 0, 32'hCAFE_BABE); tick();

        // rd_hi priority over rd_lo, and no bypass of same-cycle mthi
        rd_hi = 1'b1; mthi = 1'b1; wdata = 32'h1111_1111;
        expect_rd("rd_prio_nobypass", 0, 0, 32'hCAFE_BABE); tick();
        mthi = 1'b0; rd_lo = 1'b0;
        expect_rd("mthi_after", 0, 0, 32'h1111_1111); tick();
        rd_hi = 1'b0;

        // Multiply
        start_mul = 1'b1; alu_r2 = 32'h0000_0001; alu_r1 = 32'hFFFF_FFFE; tick();
        start_mul = 1'b0; alu_r2 = 32'h5A5A_5A5A; alu_r1 = 32'hA5A5_A5A5;
        rd_hi = 1'b1; hold_busy("mul", MUL_N);
        expect_rd("mul_hi", 0, 0, 32'h0000_0001); tick();
        rd_hi = 1'b0; rd_lo = 1'b1;
        expect_rd("mul_lo", 0, 0, 32'hFFFF_FFFE); tick();
        rd_lo = 1'b0;

        // Divide with rd_lo held from the next cycle
        start_div = 1'b1; alu_r1 = 32'd7; alu_r2 = 32'd2; tick();
        start_div = 1'b0; alu_r1 = 32'h0BAD_0BAD; alu_r2 = 32'h0BAD_0BAD;
        rd_lo = 1'b1; hold_busy("div", DIV_N);
        expect_rd("div_lo", 0, 0, 32'd7); tick();
        rd_lo = 1'b0; rd_hi = 1'b1;
        expect_rd("div_hi", 0, 0, 32'd2); tick();
        rd_hi = 1'b0;

        // start_mul and start_div together: multiply latency applies
        start_mul = 1'b1; start_div = 1'b1; alu_r2 = 32'h0000_0A0A; alu_r1 = 32'h0000_0B0B; tick();
        start_mul = 1'b0; start_div = 1'b0;
        rd_lo = 1'b1; hold_busy("both", MUL_N);
        expect_rd("both_lo", 0, 0, 32'h0000_0B0B); tick();
        rd_lo = 1'b0;

        // Second start while busy is held off, then accepted together with mthi
        start_mul = 1'b1; alu_r2 = 32'hAAAA_0001; alu_r1 = 32'h5555_0002; tick();
        alu_r2 = 32'hBBBB_0003; alu_r1 = 32'hCCCC_0004;
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        rd_lo = 1'b1; hold_busy("mul2", MUL_N);
        expect_rd("second_accept", 0, 0, 32'h5555_0002); tick();
        start_mul = 1'b0; mthi = 1'b0; rd_lo = 1'b0;
        rd_hi = 1'b1; hold_busy("mul2b", MUL_N);
        expect_rd("second_hi", 0, 0, 32'hBBBB_0003); tick();
        rd_hi = 1'b0; rd_lo = 1'b1;
        expect_rd("second_lo", 0, 0, 32'hCCCC_0004); tick();
        rd_lo = 1'b0;

        // Reset on cycle 10 of a divide, with a competing mthi
        start_div = 1'b1; alu_r1 = 32'h0000_0077; alu_r2 = 32'h0000_0066; tick();
        start_div = 1'b0;
        rd_lo = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            expect_rd($sformatf("div_rst_c%0d", i), LAT_EN, LAT_EN, 32'h0000_0077);
            tick();
        end
        rst = 1'b1; mthi = 1'b1; wdata = 32'hFFFF_0000;
        expect_rd("rst_cycle", LAT_EN, LAT_EN, 32'h0000_0077); tick();
        rst = 1'b0; mthi = 1'b0;
        expect_rd("abort_lo", 0, 0, 32'h0); tick();
        rd_lo = 1'b0; rd_hi = 1'b1;
        expect_rd("abort_hi", 0, 0, 32'h0); tick();
        rd_hi = 1'b0;
        repeat (40) tick();
        rd_lo = 1'b1; expect_rd("never_commit_lo", 0, 0, 32'h0); tick();
        rd_lo = 1'b0; rd_hi = 1'b1; expect_rd("never_commit_hi", 0, 0, 32'h0); tick();
        rd_hi = 1'b0;

        // 0xA/0xB multiply
        start_mul = 1'b1; alu_r2 = 32'h0000_000A; alu_r1 = 32'h0000_000B; tick();
        start_mul = 1'b0;
        rd_hi = 1'b1; hold_busy("ab", MUL_N);
        expect_rd("ab_hi", 0, 0, 32'h0000_000A); tick();
        rd_hi = 1'b0; rd_lo = 1'b1;
        expect_rd("ab_lo", 0, 0, 32'h0000_000B); tick();
        rd_lo = 1'b0;

        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expectations left, need 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
